// File: rtl/keypad_cursor_encoder.sv
// rtl/keypad_cursor_encoder.sv - five-button keypad to 4x6 cursor position and enter strobe
//
// Purpose:
//   Synchronizes and debounces five push buttons, turns debounced rising edges
//   into press events, moves a wrapping cursor over a 4 row x 6 column key grid
//   and strobes enter_button when center is pressed.
//
// Optional feature:
//   KEY_AUTOREPEAT_EN - when defined, held direction buttons re-issue a move
//   every REPEAT_CYCLES cycles. When undefined, REPEAT_CYCLES is ignored and no
//   repeat logic exists.
//
// Ports:
//   clk           system clock, all state on its rising edge
//   rst           synchronous active-high reset
//   btn_up/down/left/right/center  raw asynchronous button levels, active-high
//   val           registered key code under the cursor, row*6+col (0..23)
//   enter_button  single-cycle strobe confirming the key at val
//   cursor_row    registered cursor row (0..3)
//   cursor_col    registered cursor column (0..5)

module keypad_cursor_encoder #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_center,
  output logic [4:0] val,
  output logic       enter_button,
  output logic [1:0] cursor_row,
  output logic [2:0] cursor_col
);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 1");
  end
  if (REPEAT_CYCLES < 1) begin : g_bad_repeat
    $error("REPEAT_CYCLES must be at least 1");
  end

  // Button bit positions; lower index wins when events coincide.
  localparam int NB    = 5;
  localparam int BTN_C = 0;
  localparam int BTN_U = 1;
  localparam int BTN_D = 2;
  localparam int BTN_L = 3;
  localparam int BTN_R = 4;

  localparam int            DW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic [NB-1:0] btn_raw;
  logic [NB-1:0] sync1_q;
  logic [NB-1:0] sync2_q;
  logic [NB-1:0] deb_q;
  logic [NB-1:0] deb_prev_q;
  logic [NB-1:0] press;
  logic [NB-1:0] evt_d;
  logic [NB-1:0] evt_q;
  logic [DW-1:0] db_cnt_q [NB];

  assign btn_raw = {btn_right, btn_left, btn_down, btn_up, btn_center};

  // Synchronizer, per-button debouncer and the event pipeline register.
  // The debounced level flips after DEBOUNCE_CYCLES consecutive disagreeing
  // cycles; any agreeing cycle restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      evt_q      <= '0;
      for (int i = 0; i < NB; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      deb_prev_q <= deb_q;
      evt_q      <= evt_d;
      for (int i = 0; i < NB; i++) begin
        if (sync2_q[i] != deb_q[i]) begin
          if (db_cnt_q[i] == DB_LAST) begin
            deb_q[i]    <= sync2_q[i];
            db_cnt_q[i] <= '0;
          end else begin
            db_cnt_q[i] <= db_cnt_q[i] + DW'(1);
          end
        end else begin
          db_cnt_q[i] <= '0;
        end
      end
    end
  end

  // Press events are debounced rising edges only; releases are ignored.
  assign press = deb_q & ~deb_prev_q;

`ifdef KEY_AUTOREPEAT_EN
  localparam int            RW       = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYCLES - 1);

  // Entry j serves direction button j+1; center has no repeat counter.
  logic [RW-1:0] rpt_cnt_q [NB-1];
  logic [NB-1:0] rpt_fire;

  always_comb begin
    rpt_fire = '0;
    for (int j = 0; j < NB - 1; j++) begin
      rpt_fire[j+1] = deb_q[j+1] & deb_prev_q[j+1] & (rpt_cnt_q[j] == RPT_LAST);
    end
  end

  // Counting starts the cycle after the press event, so the first repeat
  // lands REPEAT_CYCLES cycles after the press; each repeat restarts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < NB - 1; j++) begin
        rpt_cnt_q[j] <= '0;
      end
    end else begin
      for (int j = 0; j < NB - 1; j++) begin
        if (deb_q[j+1] && deb_prev_q[j+1]) begin
          if (rpt_fire[j+1]) begin
            rpt_cnt_q[j] <= '0;
          end else begin
            rpt_cnt_q[j] <= rpt_cnt_q[j] + RW'(1);
          end
        end else begin
          rpt_cnt_q[j] <= '0;
        end
      end
    end
  end

  assign evt_d = press | rpt_fire;
`else
  assign evt_d = press;
`endif

  // Cursor state.
  logic [1:0] row_q, row_d;
  logic [2:0] col_q, col_d;
  logic [4:0] val_q, val_d;
  logic       enter_q, enter_d;
  logic       hold_q, hold_d;

  // hold_q blocks moves for the cycle after an enter so val stays put for
  // both the strobe cycle and the one after it.
  always_comb begin
    row_d   = row_q;
    col_d   = col_q;
    enter_d = 1'b0;
    hold_d  = 1'b0;
    if (evt_q[BTN_C]) begin
      enter_d = 1'b1;
      hold_d  = 1'b1;
    end else if (!hold_q) begin
      if (evt_q[BTN_U]) begin
        row_d = (row_q == 2'd0) ? 2'd3 : row_q - 2'd1;
      end else if (evt_q[BTN_D]) begin
        row_d = (row_q == 2'd3) ? 2'd0 : row_q + 2'd1;
      end else if (evt_q[BTN_L]) begin
        col_d = (col_q == 3'd0) ? 3'd5 : col_q - 3'd1;
      end else if (evt_q[BTN_R]) begin
        col_d = (col_q == 3'd5) ? 3'd0 : col_q + 3'd1;
      end
    end
    // row*6 = row*4 + row*2
    val_d = {1'b0, row_d, 2'b00} + {2'b00, row_d, 1'b0} + {2'b00, col_d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q   <= '0;
      col_q   <= '0;
      val_q   <= '0;
      enter_q <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      row_q   <= row_d;
      col_q   <= col_d;
      val_q   <= val_d;
      enter_q <= enter_d;
      hold_q  <= hold_d;
    end
  end

  assign val          = val_q;
  assign enter_button = enter_q;
  assign cursor_row   = row_q;
  assign cursor_col   = col_q;

endmodule

// File: tb/tb_keypad_cursor_encoder.sv
// tb/tb_keypad_cursor_encoder.sv - self-checking bench for keypad_cursor_encoder

module tb_keypad_cursor_encoder;

  localparam int D = 4;
  localparam int R = 8;
  localparam int IC = 0, IU = 1, ID = 2, IL = 3, IR = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_up, btn_down, btn_left, btn_right, btn_center;
  logic [4:0] val;
  logic       enter_button;
  logic [1:0] cursor_row;
  logic [2:0] cursor_col;

  always #5 clk = ~clk;

  keypad_cursor_encoder #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_CYCLES  (R)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .btn_center  (btn_center),
    .val         (val),
    .enter_button(enter_button),
    .cursor_row  (cursor_row),
    .cursor_col  (cursor_col)
  );

  int total = 0;
  int bad   = 0;

  // Reference model, driven by raw samples: a level is accepted after D
  // consecutive differing samples; its effect lands 4 edges after the last one.
  int         ecount = 0;
  logic [4:0] mdeb;
  int         mcnt [5];
  int         rpt_base [5];
  logic [4:0] land [16];
  int         mrow, mcol;
  logic       menter, mhold;

  task automatic model_clear();
    mdeb = '0; mrow = 0; mcol = 0; menter = 1'b0; mhold = 1'b0;
    for (int b = 0; b < 5; b++) begin mcnt[b] = 0; rpt_base[b] = -1; end
    for (int s = 0; s < 16; s++) land[s] = '0;
  endtask

  task automatic model_edge();
    logic [4:0] raw, ev;
    logic       hold_now;
    ecount++;
    if (rst) begin
      model_clear();
      return;
    end
    ev = land[ecount % 16];
    land[ecount % 16] = '0;
    hold_now = mhold;
    mhold = 1'b0;
    menter = 1'b0;
    if (ev[IC]) begin
      menter = 1'b1;
      mhold = 1'b1;
    end else if (!hold_now) begin
      if (ev[IU]) mrow = (mrow + 3) % 4;
      else if (ev[ID]) mrow = (mrow + 1) % 4;
      else if (ev[IL]) mcol = (mcol + 5) % 6;
      else if (ev[IR]) mcol = (mcol + 1) % 6;
    end
    raw = {btn_right, btn_left, btn_down, btn_up, btn_center};
    for (int b = 0; b < 5; b++) begin
      if (raw[b] != mdeb[b]) begin
        mcnt[b]++;
        if (mcnt[b] == D) begin
          mdeb[b] = raw[b];
          mcnt[b] = 0;
          if (raw[b]) begin
            land[(ecount + 4) % 16][b] = 1'b1;
            rpt_base[b] = ecount + R;
          end
        end
      end else begin
        mcnt[b] = 0;
      end
    end
`ifdef KEY_AUTOREPEAT_EN
    for (int b = 1; b < 5; b++) begin
      if (mdeb[b] && ecount == rpt_base[b]) begin
        land[(ecount + 4) % 16][b] = 1'b1;
        rpt_base[b] = rpt_base[b] + R;
      end
    end
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic set_btn(input int idx, input logic v);
    case (idx)
      IC: btn_center = v;
      IU: btn_up = v;
      ID: btn_down = v;
      IL: btn_left = v;
      default: btn_right = v;
    endcase
  endtask

  task automatic all_low();
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_center = 0;
  endtask

  task automatic do_reset();
    all_low();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
  endtask

  task automatic press(input int idx, input int n);
    set_btn(idx, 1'b1);
    repeat (n) step();
    set_btn(idx, 1'b0);
    repeat (12) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    btn_up = 1; btn_down = 0; btn_left = 1; btn_right = 1; btn_center = 1;
    repeat (3) step();
    total++; if (val !== 5'd0) begin bad++; $display("FAIL reset_val: got %0d want 0", val); end
    total++; if (cursor_row !== 2'd0) begin bad++; $display("FAIL reset_row: got %0d want 0", cursor_row); end
    total++; if (cursor_col !== 3'd0) begin bad++; $display("FAIL reset_col: got %0d want 0", cursor_col); end
    total++; if (enter_button !== 1'b0) begin bad++; $display("FAIL reset_enter: got %0d want 0", enter_button); end
    all_low();
    repeat (2) step();
    rst = 1'b0;
  endtask

  task automatic test_single_move();
    logic [4:0] exp;
    do_reset();
    btn_right = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
`ifdef KEY_AUTOREPEAT_EN
      exp = (k >= D + 3) ? 5'(1 + (k - D - 3) / R) : 5'd0;
`else
      exp = (k >= D + 3) ? 5'd1 : 5'd0;
`endif
      total++;
      if (val !== exp) begin bad++; $display("FAIL single_move k=%0d: got %0d want %0d", k, val, exp); end
    end
    btn_right = 1'b0;
    repeat (12) step();
  endtask

  task automatic test_wrap();
    do_reset();
    press(IL, 7);
    total++; if (cursor_col !== 3'd5) begin bad++; $display("FAIL wrap_left_col: got %0d want 5", cursor_col); end
    total++; if (val !== 5'd5) begin bad++; $display("FAIL wrap_left_val: got %0d want 5", val); end
    press(IU, 7);
    total++; if (cursor_row !== 2'd3) begin bad++; $display("FAIL wrap_up_row: got %0d want 3", cursor_row); end
    total++; if (val !== 5'd23) begin bad++; $display("FAIL wrap_up_val: got %0d want 23", val); end
    press(ID, 7);
    total++; if (val !== 5'd5) begin bad++; $display("FAIL wrap_down_val: got %0d want 5", val); end
  endtask

  task automatic test_enter();
    int n_en, en_k;
    logic [4:0] v_en, v_next;
    do_reset();
    press(IU, 7);
    press(IR, 7);
    total++; if (val !== 5'd19) begin bad++; $display("FAIL enter_nav_val: got %0d want 19", val); end
    n_en = 0; en_k = -10; v_en = '0; v_next = '0;
    btn_center = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (k == 7) btn_center = 1'b0;
      step();
      if (enter_button === 1'b1) begin n_en++; en_k = k; v_en = val; end
      if (k == en_k + 1) v_next = val;
    end
    total++; if (n_en != 1) begin bad++; $display("FAIL enter_count: got %0d want 1", n_en); end
    total++; if (en_k != D + 3) begin bad++; $display("FAIL enter_latency: got %0d want %0d", en_k, D + 3); end
    total++; if (v_en !== 5'd19) begin bad++; $display("FAIL enter_val: got %0d want 19", v_en); end
    total++; if (v_next !== 5'd19) begin bad++; $display("FAIL enter_val_next: got %0d want 19", v_next); end
  endtask

  task automatic test_bounce();
    do_reset();
    for (int k = 0; k < 40; k++) begin
      btn_up = ((k / 3) % 2 == 0);
      step();
      total++; if (val !== 5'd0) begin bad++; $display("FAIL bounce_val k=%0d: got %0d want 0", k, val); end
      total++; if (enter_button !== 1'b0) begin bad++; $display("FAIL bounce_enter k=%0d: got %0d want 0", k, enter_button); end
    end
    btn_up = 1'b0;
    repeat (6) step();
    press(IU, 7);
    total++; if (cursor_row !== 2'd3) begin bad++; $display("FAIL bounce_hold_row: got %0d want 3", cursor_row); end
    total++; if (val !== 5'd18) begin bad++; $display("FAIL bounce_hold_val: got %0d want 18", val); end
  endtask

  task automatic test_simultaneous();
    int n_en;
    do_reset();
    press(ID, 7);
    press(IR, 7);
    total++; if (val !== 5'd7) begin bad++; $display("FAIL simul_setup_val: got %0d want 7", val); end
    n_en = 0;
    btn_center = 1'b1; btn_right = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (k == 7) begin btn_center = 1'b0; btn_right = 1'b0; end
      step();
      if (enter_button === 1'b1) n_en++;
      total++; if (val !== 5'd7) begin bad++; $display("FAIL simul_val k=%0d: got %0d want 7", k, val); end
    end
    total++; if (n_en != 1) begin bad++; $display("FAIL simul_enter_count: got %0d want 1", n_en); end
  endtask

  task automatic test_hold_through_reset();
    logic [1:0] exp;
    all_low();
    rst = 1'b1;
    btn_down = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (k == 7) btn_down = 1'b0;
      step();
      exp = (k >= D + 3) ? 2'd1 : 2'd0;
      total++; if (cursor_row !== exp) begin bad++; $display("FAIL hold_reset_row k=%0d: got %0d want %0d", k, cursor_row, exp); end
    end
  endtask

  task automatic test_reset_mid_debounce();
    do_reset();
    btn_right = 1'b1;
    repeat (3) step();
    rst = 1'b1;
    repeat (2) step();
    btn_right = 1'b0;
    rst = 1'b0;
    for (int k = 0; k < 15; k++) begin
      step();
      total++; if (val !== 5'd0) begin bad++; $display("FAIL mid_debounce_val k=%0d: got %0d want 0", k, val); end
    end
  endtask

`ifdef KEY_AUTOREPEAT_EN
  task automatic test_autorepeat();
    logic [4:0] exp;
    do_reset();
    btn_right = 1'b1;
    for (int k = 0; k < 36; k++) begin
      step();
      exp = (k >= D + 3) ? 5'(1 + (k - D - 3) / R) : 5'd0;
      total++; if (val !== exp) begin bad++; $display("FAIL repeat_val k=%0d: got %0d want %0d", k, val, exp); end
    end
    rst = 1'b1;
    repeat (2) step();
    btn_right = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      total++; if (val !== 5'd0) begin bad++; $display("FAIL repeat_after_reset k=%0d: got %0d want 0", k, val); end
    end
  endtask
`endif

  task automatic test_random();
    logic [4:0] lvl;
    int         left [5];
    logic [4:0] exp;
    do_reset();
    lvl = '0;
    for (int b = 0; b < 5; b++) left[b] = $urandom_range(1, 20);
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < 5; b++) begin
        left[b]--;
        if (left[b] <= 0) begin
          lvl[b] = ~lvl[b];
          left[b] = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 6) : $urandom_range(5, 30);
        end
      end
      btn_center = lvl[IC]; btn_up = lvl[IU]; btn_down = lvl[ID];
      btn_left = lvl[IL]; btn_right = lvl[IR];
      rst = ($urandom_range(0, 399) == 0);
      step();
      exp = 5'(mrow * 6 + mcol);
      total++; if (val !== exp) begin bad++; $display("FAIL rand_val c=%0d: got %0d want %0d", c, val, exp); end
      total++; if (cursor_row !== 2'(mrow)) begin bad++; $display("FAIL rand_row c=%0d: got %0d want %0d", c, cursor_row, mrow); end
      total++; if (cursor_col !== 3'(mcol)) begin bad++; $display("FAIL rand_col c=%0d: got %0d want %0d", c, cursor_col, mcol); end
      total++; if (enter_button !== menter) begin bad++; $display("FAIL rand_enter c=%0d: got %0d want %0d", c, enter_button, menter); end
    end
    rst = 1'b0;
    all_low();
  endtask

  initial begin
    model_clear();
    rst = 1'b1;
    all_low();
    test_reset();
    test_single_move();
    test_wrap();
    test_enter();
    test_bounce();
    test_simultaneous();
    test_hold_through_reset();
    test_reset_mid_debounce();
`ifdef KEY_AUTOREPEAT_EN
    test_autorepeat();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
